ofs_plat_prim_ready_enable_skid_fifo: RTL and testbench
=======================================================

OFS_PLAT_PRIM_READY_ENABLE_SKID_FIFO -- requirements
Module: ofs_plat_prim_ready_enable_skid_fifo

Interface
REQ-001 The block SHALL have parameter N_DATA_BITS, default 32, meaning the payload width in bits.
REQ-002 The block SHALL have parameter N_ENTRIES, default 4, meaning the storage depth; legal values are 2 to 64, and a power of two is not required.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port enable_from_src, input, 1 bit: the source presents a valid payload.
REQ-006 The block SHALL have port data_from_src, input, N_DATA_BITS bits: the source payload.
REQ-007 The block SHALL have port ready_to_src, output, 1 bit: the block accepts a payload this cycle; this output is driven directly from a flop.
REQ-008 The block SHALL have port enable_to_dst, output, 1 bit: the head payload is valid.
REQ-009 The block SHALL have port data_to_dst, output, N_DATA_BITS bits: the head payload.
REQ-010 The block SHALL have port ready_from_dst, input, 1 bit: the destination consumes the head this cycle.
REQ-011 The block SHALL have port count, output, $clog2(N_ENTRIES+1) bits: the current occupancy.

Function
REQ-012 Purpose: the block SHALL be the upstream stage that feeds a systolic ready/enable register chain, breaking the combinational ready path so that ready_to_src never depends combinationally on ready_from_dst.
REQ-013 Push: an entry SHALL be written when enable_from_src && ready_to_src; enable_from_src while ready_to_src=0 SHALL be ignored (no write, no state change), and the source holds the payload.
REQ-014 Pop: the head SHALL be removed when enable_to_dst && ready_from_dst; ready_from_dst while empty SHALL be ignored.
REQ-015 Storage SHALL be a circular buffer with write pointer, read pointer and count; each pointer wraps from N_ENTRIES-1 to 0.
REQ-016 enable_to_dst SHALL equal (count != 0), and data_to_dst SHALL equal the entry at the read pointer, both derived from registered state only.
REQ-017 Latency: a payload pushed at edge k SHALL be visible on data_to_dst with enable_to_dst=1 after edge k when the block was empty; there is no combinational bypass from source to destination.
REQ-018 Order: payloads SHALL leave in push order, with no loss or duplication.
REQ-019 Count: count_next SHALL equal count + push - pop; a simultaneous push and pop SHALL leave count unchanged while advancing both pointers.
REQ-020 ready_to_src SHALL be registered as (count_next < N_ENTRIES).
REQ-021 Full (count=N_ENTRIES): ready_to_src SHALL be 0; a pop while full SHALL raise ready_to_src on the following cycle, and no push is possible in the same cycle as that pop.
REQ-022 Empty (count=0): enable_to_dst SHALL be 0; a push while empty SHALL make enable_to_dst=1 on the next cycle.
REQ-023 Throughput: with count < N_ENTRIES-1 and both sides continuously active, the block SHALL sustain one push and one pop per cycle indefinitely.
REQ-024 data_to_dst SHALL remain stable while enable_to_dst=1 and ready_from_dst=0.
REQ-025 count SHALL never exceed N_ENTRIES, and the pointers SHALL never exceed N_ENTRIES-1.

Reset
REQ-026 While reset_n=0 at a rising edge, count, write pointer and read pointer SHALL be cleared to 0, enable_to_dst SHALL be 0 after the edge, and ready_to_src SHALL be 0 after that edge.
REQ-027 ready_to_src SHALL become 1 on the first edge with reset_n=1.
REQ-028 Storage contents SHALL NOT be reset; data_to_dst is don't-care while enable_to_dst=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries, and no stale entry SHALL appear after reset.

Verification
REQ-030 Fill/drain: N_ENTRIES=4, ready_from_dst=0, push 0x11, 0x22, 0x33, 0x44 -> count=4, ready_to_src=0 the cycle after the 4th push, and a 5th offered payload 0x55 is not accepted; then ready_from_dst=1 -> output sequence 0x11, 0x22, 0x33, 0x44, then 0x55.
REQ-031 Streaming: both sides active for 100 cycles with an incrementing payload -> 100 pops in order, count stays at or below 1, and ready_to_src stays 1 throughout.
REQ-032 Wrap: N_ENTRIES=3, 10 push/pop cycles with random stalls -> pointers wrap 2->0 correctly, order preserved, and the scoreboard matches.
REQ-033 Simultaneous at count=2 (N_ENTRIES=4): push and pop in the same cycle -> count stays 2 and the head advances to the next entry.
REQ-034 Reset mid-stream: count=3, assert reset_n=0 for 1 cycle -> count=0, enable_to_dst=0, ready_to_src=0 then 1; the next pushed payload 0xAB is the first payload out.
REQ-035 Random ready/enable for 10k cycles with a scoreboard -> no loss, no duplication, ready_to_src is never 1 while count=N_ENTRIES, and data_to_dst is stable during stall (checked by assertion).

Source files
------------

// File: rtl/ofs_plat_prim_ready_enable_skid_fifo.sv
// ---------------------------------------------------------------------------
// ofs_plat_prim_ready_enable_skid_fifo
//
// Small circular-buffer FIFO placed in front of a systolic ready/enable
// register chain. Its job is to cut the combinational ready path: the ready
// presented to the source comes straight from a flop and is computed from
// the next occupancy, so it never depends combinationally on the
// destination's ready.
//
// Handshake rules:
//   push = enable_from_src && ready_to_src
//   pop  = enable_to_dst   && ready_from_dst
//
// The head payload and its valid flag are taken from registered state only.
// This means a payload written into an empty FIFO appears on the
// destination side one cycle after it was accepted; there is no bypass path.
//
// N_ENTRIES may be any depth from 2 to 64. It does not have to be a power of
// two, because both pointers wrap explicitly at N_ENTRIES-1.
// ---------------------------------------------------------------------------
module ofs_plat_prim_ready_enable_skid_fifo #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,

  input  logic                               enable_from_src,
  input  logic [N_DATA_BITS-1:0]             data_from_src,
  output logic                               ready_to_src,

  output logic                               enable_to_dst,
  output logic [N_DATA_BITS-1:0]             data_to_dst,
  input  logic                               ready_from_dst,

  output logic [$clog2(N_ENTRIES+1)-1:0]     count
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);

  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_ENTRIES - 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ENTRIES);

  // Advance a circular-buffer pointer. It wraps from the last slot back to
  // slot 0, so depths that are not a power of two work correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  // Payload storage. It is intentionally never reset: the data is only
  // meaningful while count is non-zero.
  logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];

  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ready;

  // -------------------------------------------------------------------------
  // Next-state signals
  // -------------------------------------------------------------------------
  logic                   w_push;
  logic                   w_pop;
  logic                   w_not_empty;
  logic [CNT_W-1:0]       w_count_next;
  logic [PTR_W-1:0]       w_wr_ptr_next;
  logic [PTR_W-1:0]       w_rd_ptr_next;
  logic                   w_ready_next;

  // Qualify the handshakes and compute the next occupancy and next pointers.
  always_comb begin
    w_not_empty   = (r_count != CNT_ZERO);

    // A source enable while ready is low does nothing; the source simply
    // holds its payload. A destination ready while empty is also ignored.
    w_push        = enable_from_src & r_ready;
    w_pop         = w_not_empty & ready_from_dst;

    w_count_next  = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      // A simultaneous push and pop leaves the occupancy unchanged.
      default: w_count_next = r_count;
    endcase

    if (w_push) begin
      w_wr_ptr_next = ptr_inc(r_wr_ptr);
    end else begin
      w_wr_ptr_next = r_wr_ptr;
    end

    if (w_pop) begin
      w_rd_ptr_next = ptr_inc(r_rd_ptr);
    end else begin
      w_rd_ptr_next = r_rd_ptr;
    end

    // Ready is based on the occupancy after this edge. When the FIFO is full
    // and the head is popped, ready therefore rises on the following cycle.
    // No push can happen in that same cycle, because ready is still low.
    w_ready_next  = (w_count_next < CNT_FULL);
  end

  // Update the control state; a synchronous reset empties the FIFO and
  // holds ready low for one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
      r_ready  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_ready  <= w_ready_next;
    end
  end

  // Write an accepted payload into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_from_src;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all of them are taken directly from registered state.
  // -------------------------------------------------------------------------
  assign ready_to_src  = r_ready;
  assign enable_to_dst = w_not_empty;
  assign data_to_dst   = r_mem[r_rd_ptr];
  assign count         = r_count;

endmodule

// File: tb/tb_ofs_plat_prim_ready_enable_skid_fifo.sv
// ---------------------------------------------------------------------------
// Testbench for ofs_plat_prim_ready_enable_skid_fifo.
//
// Two instances are exercised:
//   - depth 4, driven by directed sequences followed by a random phase;
//   - depth 3, driven by random traffic throughout, so that the pointers
//     wrap at a depth that is not a power of two.
//
// The stimulus processes push each accepted payload into an expected-data
// queue. A monitor running on the falling edge keeps a behavioural
// occupancy model and checks the following against it:
//   - count, enable_to_dst and ready_to_src;
//   - every popped payload;
//   - that the head payload stays stable during a stall.
// ---------------------------------------------------------------------------
module tb_ofs_plat_prim_ready_enable_skid_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  // Depth-4 instance
  logic        en4, rdy4, rts4, etd4;
  logic [31:0] d4, dtd4;
  logic [2:0]  cnt4;

  // Depth-3 instance
  logic        en3, rdy3, rts3, etd3;
  logic [31:0] d3, dtd3;
  logic [1:0]  cnt3;

  ofs_plat_prim_ready_enable_skid_fifo #(.N_DATA_BITS(32), .N_ENTRIES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .enable_from_src(en4), .data_from_src(d4), .ready_to_src(rts4),
    .enable_to_dst(etd4), .data_to_dst(dtd4), .ready_from_dst(rdy4),
    .count(cnt4)
  );

  ofs_plat_prim_ready_enable_skid_fifo #(.N_DATA_BITS(32), .N_ENTRIES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .enable_from_src(en3), .data_from_src(d3), .ready_to_src(rts3),
    .enable_to_dst(etd3), .data_to_dst(dtd3), .ready_from_dst(rdy3),
    .count(cnt3)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard queues, filled by the stimulus processes
  logic [31:0] exp_q4[$];
  logic [31:0] exp_q3[$];

  // Payloads seen leaving the depth-4 instance, in order
  logic [31:0] log4[$];
  int          pops3 = 0;

  // Behavioural model state, indexed 0 for depth 4 and 1 for depth 3
  int          m_count[2];
  bit          m_ready[2];
  bit          m_init[2]     = '{1'b0, 1'b0};
  bit          stall_prev[2];
  logic [31:0] prev_data[2];

  bit last_acc4;
  bit stop3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int qsize(input int i);
    if (i == 0) return exp_q4.size();
    else        return exp_q3.size();
  endfunction

  function automatic logic [31:0] qpop(input int i);
    if (i == 0) return exp_q4.pop_front();
    else        return exp_q3.pop_front();
  endfunction

  task automatic qclear(input int i);
    if (i == 0) exp_q4.delete();
    else        exp_q3.delete();
  endtask

  // Check one instance against the model, then advance the model across the
  // next rising edge.
  task automatic mon(input int i, input logic en, input logic rdy, input logic rts,
                     input logic etd, input logic [31:0] dtd, input logic [2:0] cnt);
    string       tag;
    logic [31:0] e;
    bit          push, pop;
    tag = (i == 0) ? "n4" : "n3";

    if (m_init[i]) begin
      check({tag, "_count"},  {29'd0, cnt}, m_count[i]);
      check({tag, "_enable"}, {31'd0, etd}, {31'd0, (m_count[i] != 0)});
      check({tag, "_ready"},  {31'd0, rts}, {31'd0, m_ready[i]});
      if (reset_n && stall_prev[i]) check({tag, "_stall_stable"}, dtd, prev_data[i]);
    end

    if (!reset_n) begin
      m_count[i]    = 0;
      m_ready[i]    = 1'b0;
      m_init[i]     = 1'b1;
      stall_prev[i] = 1'b0;
      qclear(i);
    end else if (m_init[i]) begin
      push = en && m_ready[i];
      pop  = (m_count[i] != 0) && rdy;
      if (pop) begin
        checks++;
        if (qsize(i) == 0) begin
          failures++;
          $display("FAIL %s_pop_underflow actual=pop required=no_pop", tag);
        end else begin
          e = qpop(i);
          if (dtd !== e) begin
            failures++;
            $display("FAIL %s_pop_data actual=%0h required=%0h", tag, dtd, e);
          end
          if (i == 0) log4.push_back(dtd);
          else        pops3++;
        end
      end
      stall_prev[i] = (m_count[i] != 0) && !rdy;
      prev_data[i]  = dtd;
      m_count[i]    = m_count[i] + int'(push) - int'(pop);
      m_ready[i]    = (m_count[i] < depth_of(i));
    end
  endtask

  // Monitor both instances on the falling edge, away from the active edge.
  always @(negedge clk) begin
    mon(0, en4, rdy4, rts4, etd4, dtd4, cnt4);
    mon(1, en3, rdy3, rts3, etd3, dtd3, {1'b0, cnt3});
  end

  a_stall_stable4: assert property (@(posedge clk) disable iff (!reset_n)
                     (etd4 && !rdy4) |=> $stable(dtd4))
    else $error("assertion a_stall_stable4");
  a_stall_stable3: assert property (@(posedge clk) disable iff (!reset_n)
                     (etd3 && !rdy3) |=> $stable(dtd3))
    else $error("assertion a_stall_stable3");
  a_no_ready_full4: assert property (@(posedge clk) disable iff (!reset_n)
                      !(rts4 && cnt4 == 3'd4))
    else $error("assertion a_no_ready_full4");

  // Drive one cycle on the depth-4 instance. This must be called at
  // posedge+1, and it returns at the next posedge+1.
  task automatic cyc4(input logic en, input logic [31:0] d, input logic rdy);
    en4       = en;
    d4        = d;
    rdy4      = rdy;
    last_acc4 = reset_n && en && rts4;
    if (last_acc4) exp_q4.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Random source and sink for the depth-3 instance. It runs at posedge+2
  // so that it sees the reset value already driven by the main process. A
  // payload that is not accepted is held until it is.
  initial begin : drv3
    bit pend;
    pend = 1'b0;
    en3  = 1'b0;
    d3   = 32'd0;
    rdy3 = 1'b0;
    @(posedge clk);
    #2;
    while (!stop3) begin
      if (!pend) begin
        en3 = ($urandom_range(0, 2) != 0);
        d3  = $urandom;
      end
      rdy3 = ($urandom_range(0, 1) != 0);
      if (reset_n && en3 && rts3) begin
        exp_q3.push_back(d3);
        pend = 1'b0;
      end else begin
        pend = en3;
      end
      @(posedge clk);
      #2;
    end
    en3  = 1'b0;
    rdy3 = 1'b0;
  end

  logic [31:0] fd_exp[5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

  initial begin : main
    bit          sent55, pend, ok;
    logic        en;
    logic        rdy;
    logic [31:0] hd;
    int          bias;

    reset_n = 1'b0;
    en4     = 1'b0;
    d4      = 32'd0;
    rdy4    = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cyc4(1'b0, 32'd0, 1'b0);
    check("rst_count",  {29'd0, cnt4}, 32'd0);
    check("rst_enable", {31'd0, etd4}, 32'd0);
    check("rst_ready",  {31'd0, rts4}, 32'd0);
    reset_n = 1'b1;
    cyc4(1'b0, 32'd0, 1'b0);
    check("rst_ready_rise", {31'd0, rts4}, 32'd1);

    // Fill to full, then drain
    for (int j = 0; j < 4; j++) cyc4(1'b1, fd_exp[j], 1'b0);
    check("fill_count", {29'd0, cnt4}, 32'd4);
    check("fill_ready", {31'd0, rts4}, 32'd0);
    for (int j = 0; j < 3; j++) cyc4(1'b1, 32'h55, 1'b0);
    check("full_reject_count", {29'd0, cnt4}, 32'd4);
    log4.delete();
    sent55 = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc4(!sent55, 32'h55, 1'b1);
      if (last_acc4) sent55 = 1'b1;
    end
    check("drain_len", log4.size(), 32'd5);
    for (int j = 0; j < 5; j++) begin
      if (j < log4.size()) check("drain_order", log4[j], fd_exp[j]);
    end

    // Streaming: both sides active on every cycle
    log4.delete();
    for (int j = 0; j < 100; j++) begin
      cyc4(1'b1, 32'h100 + j, 1'b1);
      check("stream_count_le1", {31'd0, (cnt4 <= 3'd1)}, 32'd1);
      check("stream_ready",     {31'd0, rts4}, 32'd1);
    end
    for (int j = 0; j < 3; j++) cyc4(1'b0, 32'd0, 1'b1);
    check("stream_pops", log4.size(), 32'd100);
    ok = (log4.size() == 100);
    for (int j = 0; j < log4.size(); j++) if (log4[j] !== 32'h100 + j) ok = 1'b0;
    check("stream_order", {31'd0, ok}, 32'd1);

    // Simultaneous push and pop at count 2
    cyc4(1'b1, 32'hA1, 1'b0);
    cyc4(1'b1, 32'hA2, 1'b0);
    check("simul_pre_count", {29'd0, cnt4}, 32'd2);
    cyc4(1'b1, 32'hA3, 1'b1);
    check("simul_count", {29'd0, cnt4}, 32'd2);
    check("simul_head",  dtd4, 32'hA2);
    for (int j = 0; j < 4; j++) cyc4(1'b0, 32'd0, 1'b1);
    check("simul_drained", {29'd0, cnt4}, 32'd0);

    // Reset in the middle of operation, with three entries stored
    for (int j = 0; j < 3; j++) cyc4(1'b1, 32'hB0 + j, 1'b0);
    check("mid_pre_count", {29'd0, cnt4}, 32'd3);
    reset_n = 1'b0;
    cyc4(1'b0, 32'd0, 1'b0);
    check("mid_rst_count",  {29'd0, cnt4}, 32'd0);
    check("mid_rst_enable", {31'd0, etd4}, 32'd0);
    check("mid_rst_ready",  {31'd0, rts4}, 32'd0);
    reset_n = 1'b1;
    cyc4(1'b0, 32'd0, 1'b0);
    check("mid_rst_ready_rise", {31'd0, rts4}, 32'd1);
    log4.delete();
    cyc4(1'b1, 32'hAB, 1'b0);
    check("mid_first_enable", {31'd0, etd4}, 32'd1);
    check("mid_first_data",   dtd4, 32'hAB);
    cyc4(1'b0, 32'd0, 1'b1);
    check("mid_first_out_len", log4.size(), 32'd1);
    if (log4.size() > 0) check("mid_first_out", log4[0], 32'hAB);

    // Random traffic. The sink bias changes so the FIFO visits full, empty
    // and streaming regimes.
    pend = 1'b0;
    hd   = 32'd0;
    for (int k = 0; k < 10000; k++) begin
      bias = (k / 500) % 3;
      if (pend) begin
        en = 1'b1;
      end else begin
        en = ($urandom_range(0, 3) != 0);
        hd = $urandom;
      end
      case (bias)
        0:       rdy = ($urandom_range(0, 3) == 0);
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = ($urandom_range(0, 1) != 0);
      endcase
      cyc4(en, hd, rdy);
      pend = en && !last_acc4;
    end
    for (int j = 0; j < 6; j++) cyc4(1'b0, 32'd0, 1'b1);
    check("rand_drained", {29'd0, cnt4}, 32'd0);

    stop3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("n3_enough_pops", {31'd0, (pops3 > 10)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
